// File: rtl/irq_ctrl_pkg.sv
// Shared definitions for the interrupt controller: FSM states, register
// offsets within the controller window and default sizing.
package irq_ctrl_pkg;

   // Controller handshake states; IRQ is asserted only while in ST_REQ
   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_REQ     = 2'd1,
      ST_SERVICE = 2'd2
   } state_t;

   // Word offsets decoded from ADD_I[4:2]
   localparam logic [2:0] ADDR_CTRL = 3'b000;
   localparam logic [2:0] ADDR_MASK = 3'b001;
   localparam logic [2:0] ADDR_TRIG = 3'b010;
   localparam logic [2:0] ADDR_PEND = 3'b011;
   localparam logic [2:0] ADDR_ISR  = 3'b100;

   // Global interrupt enable bit inside CTRL
   localparam int CTRL_GIE = 0;

   // Default sizing: six sources mapped onto HWInt[7:2]
   localparam int DEF_NSRC = 6;
   localparam int DEF_IDW  = 3;

endpackage

// File: rtl/irq_prio_enc.sv
// Fixed-priority encoder: the lowest-numbered active request wins, so
// timer0 on bit 0 always has the highest priority.
module irq_prio_enc
   import irq_ctrl_pkg::*;
#(
   parameter int NSRC = DEF_NSRC,
   parameter int IDW  = DEF_IDW
) (
   input  logic [NSRC-1:0] req,
   output logic            valid,
   output logic [IDW-1:0]  id
);

   // Scan from the top down so the last hit, the lowest index, sets the id
   always_comb begin
      valid = |req;
      id    = '0;
      for (int i = NSRC - 1; i >= 0; i--) begin
         if (req[i]) begin
            id = IDW'(i);
         end
      end
   end

endmodule

// File: rtl/irq_ctrl.sv
// Interrupt controller between device IRQ lines and CP0. Latches and masks
// source requests, raises one IRQ, and runs the request / ack / eret
// handshake, pulsing EOI to the serviced source when the handler returns.
module irq_ctrl
   import irq_ctrl_pkg::*;
#(
   parameter int NSRC = DEF_NSRC,
   parameter int IDW  = DEF_IDW
) (
   input  logic            CLK_I,
   input  logic            RST_I,
   input  logic [4:2]      ADD_I,
   input  logic            WE_I,
   input  logic [31:0]     DAT_I,
   output logic [31:0]     DAT_O,
   input  logic [NSRC-1:0] SRC_I,
   input  logic            INT_ACK,
   input  logic            exlclr,
   output logic            IRQ,
   output logic [NSRC-1:0] EOI_O
);

   logic            gie;
   logic [NSRC-1:0] mask;
   logic [NSRC-1:0] trig;
   logic [NSRC-1:0] pend;
   logic [NSRC-1:0] pend_next;
   logic [NSRC-1:0] src_d;
   logic [NSRC-1:0] edge_set;
   logic [NSRC-1:0] w1c_clr;
   logic [NSRC-1:0] ack_clr;
   logic [NSRC-1:0] eff;
   logic [IDW-1:0]  isr_id;
   logic [IDW-1:0]  prio_id;
   logic            prio_valid;
   logic            take_ack;
   state_t          state;
   state_t          state_next;
   logic            unused_dat;

   // Only the low NSRC data bits carry register content
   assign unused_dat = ^DAT_I[31:NSRC];

   assign edge_set = SRC_I & ~src_d;
   assign w1c_clr  = (WE_I && (ADD_I == ADDR_PEND)) ? DAT_I[NSRC-1:0] : '0;
   assign eff      = pend & mask & {NSRC{gie}};
   assign take_ack = (state == ST_REQ) && INT_ACK;
   assign ack_clr  = (take_ack && prio_valid) ? (NSRC'(1'b1) << prio_id) : '0;
   assign IRQ      = (state == ST_REQ);

   irq_prio_enc #(
      .NSRC (NSRC),
      .IDW  (IDW)
   ) u_prio (
      .req   (eff),
      .valid (prio_valid),
      .id    (prio_id)
   );

   // Edge bits hold until W1C or ack, a fresh edge beating both; level bits track the line
   always_comb begin
      pend_next = (trig & ((pend & ~w1c_clr & ~ack_clr) | edge_set)) | (~trig & SRC_I);
   end

   // Register file, edge-detect history, pending bits and the in-service id
   always_ff @(posedge CLK_I or negedge RST_I) begin
      if (!RST_I) begin
         gie    <= 1'b0;
         mask   <= '0;
         trig   <= '0;
         pend   <= '0;
         src_d  <= '0;
         isr_id <= '0;
      end else begin
         src_d <= SRC_I;
         pend  <= pend_next;
         if (WE_I && (ADD_I == ADDR_CTRL)) begin
            gie <= DAT_I[CTRL_GIE];
         end
         if (WE_I && (ADD_I == ADDR_MASK)) begin
            mask <= DAT_I[NSRC-1:0];
         end
         if (WE_I && (ADD_I == ADDR_TRIG)) begin
            trig <= DAT_I[NSRC-1:0];
         end
         if (take_ack) begin
            isr_id <= prio_id;
         end
      end
   end

   // Handshake state register
   always_ff @(posedge CLK_I or negedge RST_I) begin
      if (!RST_I) begin
         state <= ST_IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next state: ack beats a simultaneous eret in REQ, no nesting while in service
   always_comb begin
      state_next = state;
      case (state)
         ST_IDLE: begin
            if (|eff) begin
               state_next = ST_REQ;
            end
         end
         ST_REQ: begin
            if (INT_ACK) begin
               state_next = ST_SERVICE;
            end else if (!(|eff)) begin
               state_next = ST_IDLE;
            end
         end
         ST_SERVICE: begin
            if (exlclr) begin
               state_next = ST_IDLE;
            end
         end
         default: state_next = ST_IDLE;
      endcase
   end

   // End-of-service pulse to the source being serviced, only in the eret cycle
   always_comb begin
      EOI_O = '0;
      if ((state == ST_SERVICE) && exlclr) begin
         EOI_O = NSRC'(1'b1) << isr_id;
      end
   end

   // Combinational read-back; unused offsets and unused upper bits read zero
   always_comb begin
      DAT_O = '0;
      case (ADD_I)
         ADDR_CTRL: DAT_O = 32'(gie);
         ADDR_MASK: DAT_O = 32'(mask);
         ADDR_TRIG: DAT_O = 32'(trig);
         ADDR_PEND: DAT_O = 32'(pend);
         ADDR_ISR: begin
            DAT_O     = 32'(isr_id);
            DAT_O[31] = (state == ST_SERVICE);
         end
         default: DAT_O = '0;
      endcase
   end

endmodule

// File: tb/tb_irq_ctrl.sv
// Bench for irq_ctrl: a per-cycle vector table for register access and the
// basic edge-source handshake, then hand-written multi-cycle sequences.
module tb_irq_ctrl;

   logic        CLK_I;
   logic        RST_I;
   logic [2:0]  ADD_I;
   logic        WE_I;
   logic [31:0] DAT_I;
   logic [31:0] DAT_O;
   logic [5:0]  SRC_I;
   logic        INT_ACK;
   logic        exlclr;
   logic        IRQ;
   logic [5:0]  EOI_O;

   typedef struct {
      logic [2:0]  add;
      logic        we;
      logic [31:0] dat;
      logic [5:0]  src;
      logic        ack;
      logic        exl;
      logic        irq;
      logic [5:0]  eoi;
      logic        chk;
      logic [31:0] rd;
   } vec_t;

   typedef struct {
      logic        irq;
      logic [5:0]  eoi;
      logic        chk;
      logic [31:0] rd;
   } exp_t;

   exp_t sb[$];
   vec_t tbl[20];
   int   total = 0;
   int   bad   = 0;

   irq_ctrl #(
      .NSRC (6),
      .IDW  (3)
   ) dut (
      .CLK_I   (CLK_I),
      .RST_I   (RST_I),
      .ADD_I   (ADD_I),
      .WE_I    (WE_I),
      .DAT_I   (DAT_I),
      .DAT_O   (DAT_O),
      .SRC_I   (SRC_I),
      .INT_ACK (INT_ACK),
      .exlclr  (exlclr),
      .IRQ     (IRQ),
      .EOI_O   (EOI_O)
   );

   // Free-running 10 ns clock
   initial CLK_I = 1'b0;
   always #5 CLK_I = ~CLK_I;

   // Hard stop in case the sequence ever stalls
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout want finish");
      $fatal(1, "[TB] watchdog expired");
   end

   function automatic vec_t mkVec(input logic [2:0] add, input logic we, input logic [31:0] dat,
                                  input logic [5:0] src, input logic ack, input logic exl,
                                  input logic irq, input logic [5:0] eoi, input logic chk,
                                  input logic [31:0] rd);
      vec_t v;
      v.add = add; v.we = we; v.dat = dat; v.src = src; v.ack = ack; v.exl = exl;
      v.irq = irq; v.eoi = eoi; v.chk = chk; v.rd = rd;
      return v;
   endfunction

   task automatic applyStimulus(input vec_t v);
      ADD_I   = v.add;
      WE_I    = v.we;
      DAT_I   = v.dat;
      SRC_I   = v.src;
      INT_ACK = v.ack;
      exlclr  = v.exl;
   endtask

   task automatic expectOut(input logic irq, input logic [5:0] eoi, input logic chk,
                            input logic [31:0] rd);
      exp_t e;
      e.irq = irq; e.eoi = eoi; e.chk = chk; e.rd = rd;
      sb.push_back(e);
   endtask

   task automatic checkOutput(input string name);
      exp_t e;
      if (sb.size() == 0) begin
         total++; bad++;
         $display("[TB] FAIL %s scoreboard: got empty want entry", name);
         return;
      end
      e = sb.pop_front();
      total++;
      if (IRQ !== e.irq) begin
         bad++;
         $display("[TB] FAIL %s irq: got %0b want %0b", name, IRQ, e.irq);
      end
      total++;
      if (EOI_O !== e.eoi) begin
         bad++;
         $display("[TB] FAIL %s eoi: got %02h want %02h", name, EOI_O, e.eoi);
      end
      if (e.chk) begin
         total++;
         if (DAT_O !== e.rd) begin
            bad++;
            $display("[TB] FAIL %s dat: got %08h want %08h", name, DAT_O, e.rd);
         end
      end
   endtask

   // One clock cycle: drive at edge+1, check mid-cycle, advance to next edge+1
   task automatic runCycle(input vec_t v, input string name);
      applyStimulus(v);
      expectOut(v.irq, v.eoi, v.chk, v.rd);
      #2;
      checkOutput(name);
      @(posedge CLK_I);
      #1;
   endtask

   initial begin
      // Register setup, edge on timer0, ack, eret, unused offsets, stray eret
      tbl[0]  = mkVec(3'd0, 1, 32'h1,        6'h00, 0, 0, 0, 6'h00, 1, 32'h0);
      tbl[1]  = mkVec(3'd1, 1, 32'hFFFF_FFC1, 6'h00, 0, 0, 0, 6'h00, 1, 32'h0);
      tbl[2]  = mkVec(3'd2, 1, 32'h1,        6'h00, 0, 0, 0, 6'h00, 1, 32'h0);
      tbl[3]  = mkVec(3'd0, 0, 32'h0,        6'h00, 0, 0, 0, 6'h00, 1, 32'h1);
      tbl[4]  = mkVec(3'd1, 0, 32'h0,        6'h00, 0, 0, 0, 6'h00, 1, 32'h1);
      tbl[5]  = mkVec(3'd2, 0, 32'h0,        6'h00, 0, 0, 0, 6'h00, 1, 32'h1);
      tbl[6]  = mkVec(3'd3, 0, 32'h0,        6'h01, 0, 0, 0, 6'h00, 1, 32'h0);
      tbl[7]  = mkVec(3'd3, 0, 32'h0,        6'h00, 0, 0, 0, 6'h00, 1, 32'h1);
      tbl[8]  = mkVec(3'd4, 0, 32'h0,        6'h00, 0, 0, 1, 6'h00, 1, 32'h0);
      tbl[9]  = mkVec(3'd3, 0, 32'h0,        6'h00, 1, 0, 1, 6'h00, 1, 32'h1);
      tbl[10] = mkVec(3'd4, 0, 32'h0,        6'h00, 0, 0, 0, 6'h00, 1, 32'h8000_0000);
      tbl[11] = mkVec(3'd3, 0, 32'h0,        6'h00, 0, 0, 0, 6'h00, 1, 32'h0);
      tbl[12] = mkVec(3'd4, 0, 32'h0,        6'h00, 0, 1, 0, 6'h01, 1, 32'h8000_0000);
      tbl[13] = mkVec(3'd4, 0, 32'h0,        6'h00, 0, 0, 0, 6'h00, 1, 32'h0);
      tbl[14] = mkVec(3'd5, 0, 32'h0,        6'h00, 0, 0, 0, 6'h00, 1, 32'h0);
      tbl[15] = mkVec(3'd6, 0, 32'h0,        6'h00, 0, 0, 0, 6'h00, 1, 32'h0);
      tbl[16] = mkVec(3'd7, 0, 32'h0,        6'h00, 0, 0, 0, 6'h00, 1, 32'h0);
      tbl[17] = mkVec(3'd5, 1, 32'hFFFF_FFFF, 6'h00, 0, 0, 0, 6'h00, 1, 32'h0);
      tbl[18] = mkVec(3'd0, 0, 32'h0,        6'h00, 0, 0, 0, 6'h00, 1, 32'h1);
      tbl[19] = mkVec(3'd0, 0, 32'h0,        6'h00, 0, 1, 0, 6'h00, 1, 32'h1);

      RST_I = 1'b0;
      applyStimulus(mkVec(3'd0, 0, 32'h0, 6'h00, 0, 0, 0, 6'h00, 0, 32'h0));
      repeat (2) @(posedge CLK_I);
      #1;

      // Reset state: outputs idle and every register reads zero
      for (int a = 0; a < 5; a++) begin
         ADD_I = 3'(a);
         #1;
         expectOut(0, 6'h00, 1, 32'h0);
         checkOutput($sformatf("reset_rd%0d", a));
      end
      @(posedge CLK_I);
      #1;
      RST_I = 1'b1;

      for (int i = 0; i < 20; i++) begin
         runCycle(tbl[i], $sformatf("vec%0d", i));
      end

      // Simultaneous edges on sources 2 and 1: id 1 first, id 2 after eret
      runCycle(mkVec(3'd1, 1, 32'h3F, 6'h00, 0, 0, 0, 6'h00, 1, 32'h1),  "t2_mask");
      runCycle(mkVec(3'd2, 1, 32'h3F, 6'h00, 0, 0, 0, 6'h00, 1, 32'h1),  "t2_trig");
      runCycle(mkVec(3'd3, 0, 32'h0,  6'h06, 0, 0, 0, 6'h00, 1, 32'h0),  "t2_edge");
      runCycle(mkVec(3'd3, 0, 32'h0,  6'h00, 0, 0, 0, 6'h00, 1, 32'h6),  "t2_pend");
      runCycle(mkVec(3'd3, 0, 32'h0,  6'h00, 1, 0, 1, 6'h00, 1, 32'h6),  "t2_ack1");
      runCycle(mkVec(3'd4, 0, 32'h0,  6'h00, 0, 0, 0, 6'h00, 1, 32'h8000_0001), "t2_isr1");
      runCycle(mkVec(3'd3, 0, 32'h0,  6'h00, 0, 1, 0, 6'h02, 1, 32'h4),  "t2_eret1");
      runCycle(mkVec(3'd4, 0, 32'h0,  6'h00, 0, 0, 0, 6'h00, 1, 32'h1),  "t2_idle");
      runCycle(mkVec(3'd4, 0, 32'h0,  6'h00, 1, 0, 1, 6'h00, 1, 32'h1),  "t2_ack2");
      runCycle(mkVec(3'd4, 0, 32'h0,  6'h00, 0, 1, 0, 6'h04, 1, 32'h8000_0002), "t2_eret2");
      runCycle(mkVec(3'd3, 0, 32'h0,  6'h00, 0, 0, 0, 6'h00, 1, 32'h0),  "t2_done");

      // Level source 3 drops before ack: request withdrawn, later ack ignored
      runCycle(mkVec(3'd1, 1, 32'h08, 6'h00, 0, 0, 0, 6'h00, 1, 32'h3F), "t3_mask");
      runCycle(mkVec(3'd2, 1, 32'h00, 6'h00, 0, 0, 0, 6'h00, 1, 32'h3F), "t3_trig");
      runCycle(mkVec(3'd3, 0, 32'h0,  6'h08, 0, 0, 0, 6'h00, 1, 32'h0),  "t3_rise");
      runCycle(mkVec(3'd3, 0, 32'h0,  6'h08, 0, 0, 0, 6'h00, 1, 32'h8),  "t3_pend");
      runCycle(mkVec(3'd3, 0, 32'h0,  6'h00, 0, 0, 1, 6'h00, 0, 32'h0),  "t3_req");
      runCycle(mkVec(3'd3, 0, 32'h0,  6'h00, 0, 0, 1, 6'h00, 1, 32'h0),  "t3_drop");
      runCycle(mkVec(3'd3, 0, 32'h0,  6'h00, 1, 0, 0, 6'h00, 1, 32'h0),  "t3_lateack");
      runCycle(mkVec(3'd4, 0, 32'h0,  6'h00, 0, 0, 0, 6'h00, 1, 32'h2),  "t3_isr");

      // W1C versus edge on source 0, then mask removed while requesting
      runCycle(mkVec(3'd2, 1, 32'h01, 6'h00, 0, 0, 0, 6'h00, 1, 32'h0),  "t4_trig");
      runCycle(mkVec(3'd1, 1, 32'h00, 6'h00, 0, 0, 0, 6'h00, 1, 32'h8),  "t4_mask0");
      runCycle(mkVec(3'd3, 0, 32'h0,  6'h01, 0, 0, 0, 6'h00, 1, 32'h0),  "t4_edge");
      runCycle(mkVec(3'd3, 1, 32'h01, 6'h00, 0, 0, 0, 6'h00, 1, 32'h1),  "t4_w1c");
      runCycle(mkVec(3'd3, 1, 32'h01, 6'h01, 0, 0, 0, 6'h00, 1, 32'h0),  "t4_w1c_edge");
      runCycle(mkVec(3'd3, 0, 32'h0,  6'h00, 0, 0, 0, 6'h00, 1, 32'h1),  "t4_setwins");
      runCycle(mkVec(3'd1, 1, 32'h01, 6'h00, 0, 0, 0, 6'h00, 1, 32'h0),  "t4_mask1");
      runCycle(mkVec(3'd3, 0, 32'h0,  6'h00, 0, 0, 0, 6'h00, 1, 32'h1),  "t4_idle");
      runCycle(mkVec(3'd1, 1, 32'h00, 6'h00, 0, 0, 1, 6'h00, 1, 32'h1),  "t4_req_unmask");
      runCycle(mkVec(3'd1, 0, 32'h0,  6'h00, 0, 0, 1, 6'h00, 1, 32'h0),  "t4_req_hold");
      runCycle(mkVec(3'd3, 0, 32'h0,  6'h00, 0, 0, 0, 6'h00, 1, 32'h1),  "t4_irq_drop");

      // Ack and eret together in REQ, then a re-pending edge while in service
      runCycle(mkVec(3'd1, 1, 32'h01, 6'h00, 0, 0, 0, 6'h00, 1, 32'h0),  "t6_mask");
      runCycle(mkVec(3'd3, 0, 32'h0,  6'h00, 0, 0, 0, 6'h00, 1, 32'h1),  "t6_idle");
      runCycle(mkVec(3'd3, 0, 32'h0,  6'h00, 1, 1, 1, 6'h00, 1, 32'h1),  "t6_ack_eret");
      runCycle(mkVec(3'd4, 0, 32'h0,  6'h01, 0, 0, 0, 6'h00, 1, 32'h8000_0000), "t6_service");
      runCycle(mkVec(3'd3, 0, 32'h0,  6'h00, 0, 0, 0, 6'h00, 1, 32'h1),  "t6_repend");

      // Asynchronous reset mid-cycle while in service with an eret on the line
      applyStimulus(mkVec(3'd4, 0, 32'h0, 6'h00, 0, 1, 0, 6'h00, 0, 32'h0));
      #1;
      expectOut(0, 6'h01, 1, 32'h8000_0000);
      checkOutput("t5_before");
      #1;
      RST_I = 1'b0;
      #1;
      expectOut(0, 6'h00, 1, 32'h0);
      checkOutput("t5_rst_isr");
      for (int a = 0; a < 4; a++) begin
         ADD_I = 3'(a);
         #1;
         expectOut(0, 6'h00, 1, 32'h0);
         checkOutput($sformatf("t5_rst_rd%0d", a));
      end

      exlclr = 1'b0;
      @(posedge CLK_I);
      #1;
      RST_I = 1'b1;
      @(posedge CLK_I);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
